// File: rtl/pipe_stage_pkg.sv
// Shared pipeline constants: NOP encodings per stage boundary and occupancy helpers.
// Stage instances pick their bubble payload from here via NOP_VALUE.
package pipe_stage_pkg;

  localparam int unsigned PIPE_W = 40;

  localparam logic [PIPE_W-1:0] NOP_ZERO   = 40'h00_0000_0000;
  localparam logic [PIPE_W-1:0] NOP_IF_ID  = 40'h00_0000_0013;
  localparam logic [PIPE_W-1:0] NOP_EX_MEM = 40'h40_0000_0013;
  localparam logic [PIPE_W-1:0] NOP_MEM_WB = 40'h80_0000_0013;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic occ_e occ_count(input logic main_v, input logic skid_v);
    occ_e occ;
    case ({main_v, skid_v})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_FULL;
      default: occ = OCC_ONE;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: payload plus valid bit, with load and clear-to-NOP.
// An invalid entry always holds NOP_VALUE so a stale payload never lingers.
module pipe_slot
  import pipe_stage_pkg::*;
#(
  parameter int unsigned          WIDTH     = 40,
  parameter logic [WIDTH-1:0]     NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next-state: clear beats load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = NOP_VALUE;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = valid_i ? data_i : NOP_VALUE;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Entry registers with asynchronous reset to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage with optional skid entry, flush and a saturating stall counter.
// SKID=1 keeps o_ready a pure flop output; SKID=0 trades that for a single entry.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned      WIDTH     = 40,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      SKID      = 1,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_flush,
  output logic [1:0]       o_count,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_data;
  logic             up_xfer, drain, main_load, main_vin;
  logic [WIDTH-1:0] main_din;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign drain     = main_v & i_ready;
  assign up_xfer   = i_valid & o_ready & ~i_flush;
  assign main_load = ~main_v | drain;

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_load, skid_vin;
      logic [WIDTH-1:0] skid_data;

      // Main refills from the skid entry first so order is preserved.
      always_comb begin
        main_vin = 1'b0;
        main_din = i_data;
        if (skid_v) begin
          main_vin = 1'b1;
          main_din = skid_data;
        end else begin
          main_vin = up_xfer;
          main_din = i_data;
        end
      end

      assign skid_vin  = main_v & ~drain & up_xfer;
      assign skid_load = skid_vin | (main_load & skid_v);
      assign o_ready   = ~skid_v;

      pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (i_flush),
        .valid_i (skid_vin),
        .data_i  (i_data),
        .valid_o (skid_v),
        .data_o  (skid_data)
      );
    end else begin : g_single
      assign main_vin = up_xfer;
      assign main_din = i_data;
      assign skid_v   = 1'b0;
      assign o_ready  = i_ready | ~main_v;
    end
  endgenerate

  pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (i_flush),
    .valid_i (main_vin),
    .data_i  (main_din),
    .valid_o (main_v),
    .data_o  (main_data)
  );

  // Output payload: bubble encoding whenever nothing is valid.
  always_comb begin
    o_data = NOP_VALUE;
    if (main_v) begin
      o_data = main_data;
    end else begin
      o_data = NOP_VALUE;
    end
  end

  assign o_valid = main_v;
  assign o_count = occ_count(main_v, skid_v);

  // Stall counter next-state; flush deliberately has no effect here.
  always_comb begin
    stall_d = stall_q;
    if (main_v && !i_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench: skid instance (CNT_W=4, NOP=0xEE) and a single-entry instance.
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rst;

  logic       a_i_valid, a_o_ready, a_o_valid, a_i_ready, a_i_flush;
  logic [7:0] a_i_data, a_o_data;
  logic [1:0] a_o_count;
  logic [3:0] a_o_stall;

  logic        b_i_valid, b_o_ready, b_o_valid, b_i_ready, b_i_flush;
  logic [7:0]  b_i_data, b_o_data;
  logic [1:0]  b_o_count;
  logic [15:0] b_o_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(8), .NOP_VALUE(8'hEE), .SKID(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_valid(a_i_valid), .o_ready(a_o_ready), .i_data(a_i_data),
    .o_valid(a_o_valid), .i_ready(a_i_ready), .o_data(a_o_data),
    .i_flush(a_i_flush), .o_count(a_o_count), .o_stall_cycles(a_o_stall)
  );

  pipe_stage #(.WIDTH(8), .NOP_VALUE(8'h00), .SKID(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_valid(b_i_valid), .o_ready(b_o_ready), .i_data(b_i_data),
    .o_valid(b_o_valid), .i_ready(b_i_ready), .o_data(b_o_data),
    .i_flush(b_i_flush), .o_count(b_o_count), .o_stall_cycles(b_o_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt, exp_out, nstall;
    bit full;

    rst = 1'b1;
    a_i_valid = 1'b0; a_i_ready = 1'b0; a_i_data = 8'h00; a_i_flush = 1'b0;
    b_i_valid = 1'b0; b_i_ready = 1'b0; b_i_data = 8'h00; b_i_flush = 1'b0;
    #1;
    check_eq("rst_valid", a_o_valid, 0);
    check_eq("rst_count", a_o_count, 0);
    check_eq("rst_data",  a_o_data, 32'hEE);
    check_eq("rst_stall", a_o_stall, 0);
    check_eq("rst_ready", a_o_ready, 1);
    tick();
    rst = 1'b0;

    // Back-to-back stream with downstream always ready
    a_i_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a_i_valid = 1'b1;
      a_i_data  = 8'(k);
      #1;
      check_eq("str_ready", a_o_ready, 1);
      tick();
      check_eq("str_valid", a_o_valid, 1);
      check_eq("str_data",  a_o_data, k);
      check_eq("str_count", a_o_count, 1);
    end
    a_i_valid = 1'b0;
    tick();
    check_eq("str_empty", a_o_valid, 0);
    check_eq("str_nop",   a_o_data, 32'hEE);
    check_eq("str_stall", a_o_stall, 0);

    // Back-pressure fills the skid entry, then drains in order
    a_i_ready = 1'b0;
    a_i_valid = 1'b1; a_i_data = 8'hAA;
    tick();
    check_eq("bp_ready1", a_o_ready, 1);
    a_i_data = 8'hBB;
    tick();
    check_eq("bp_count2", a_o_count, 2);
    check_eq("bp_ready0", a_o_ready, 0);
    check_eq("bp_dataAA", a_o_data, 32'hAA);
    check_eq("bp_stall1", a_o_stall, 1);
    a_i_valid = 1'b0; a_i_ready = 1'b1;
    #1;
    check_eq("bp_outAA", a_o_data, 32'hAA);
    tick();
    check_eq("bp_outBB", a_o_data, 32'hBB);
    check_eq("bp_count1", a_o_count, 1);
    check_eq("bp_ready", a_o_ready, 1);
    tick();
    check_eq("bp_drained", a_o_valid, 0);

    // Flush with both entries full and a payload on the input
    a_i_ready = 1'b0;
    a_i_valid = 1'b1; a_i_data = 8'h11;
    tick();
    a_i_data = 8'h22;
    tick();
    a_i_data = 8'hCC; a_i_flush = 1'b1;
    #1;
    check_eq("fl_hold", a_o_data, 32'h11);
    tick();
    check_eq("fl_valid", a_o_valid, 0);
    check_eq("fl_count", a_o_count, 0);
    check_eq("fl_nop",   a_o_data, 32'hEE);
    check_eq("fl_ready", a_o_ready, 1);
    check_eq("fl_stall", a_o_stall, 3);
    a_i_data = 8'hCD;
    tick();
    check_eq("fl_discard", a_o_valid, 0);
    a_i_flush = 1'b0; a_i_valid = 1'b0;
    tick();
    check_eq("fl_after", a_o_valid, 0);

    // Stall counter saturation (CNT_W=4)
    a_i_valid = 1'b1; a_i_data = 8'h33;
    tick();
    a_i_valid = 1'b0;
    check_eq("sat_start", a_o_stall, 3);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 11) check_eq("sat_14", a_o_stall, 14);
    end
    check_eq("sat_15", a_o_stall, 15);
    check_eq("sat_data", a_o_data, 32'h33);
    a_i_ready = 1'b1;
    tick();
    check_eq("sat_drain", a_o_valid, 0);
    check_eq("sat_hold", a_o_stall, 15);

    // Asynchronous reset between edges with two entries held
    a_i_ready = 1'b0;
    a_i_valid = 1'b1; a_i_data = 8'h44;
    tick();
    a_i_data = 8'h55;
    tick();
    a_i_valid = 1'b0;
    check_eq("ar_count2", a_o_count, 2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", a_o_valid, 0);
    check_eq("ar_count", a_o_count, 0);
    check_eq("ar_data",  a_o_data, 32'hEE);
    check_eq("ar_stall", a_o_stall, 0);
    check_eq("ar_ready", a_o_ready, 1);
    rst = 1'b0;
    a_i_valid = 1'b1; a_i_data = 8'h11; a_i_ready = 1'b1;
    tick();
    check_eq("ar_first_v", a_o_valid, 1);
    check_eq("ar_first_d", a_o_data, 32'h11);
    a_i_valid = 1'b0;
    tick();
    check_eq("ar_empty", a_o_count, 0);

    // Single-entry instance: continuous valid, toggling downstream ready
    nxt = 1; exp_out = 1; nstall = 0; full = 1'b0;
    b_i_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      b_i_ready = c[0];
      b_i_data  = 8'(nxt);
      #1;
      check_eq("s0_ready", b_o_ready, full ? 32'(b_i_ready) : 32'd1);
      check_eq("s0_count", b_o_count, full ? 32'd1 : 32'd0);
      if (full) begin
        check_eq("s0_data", b_o_data, exp_out);
        if (b_i_ready) exp_out++;
        else nstall++;
      end
      if (!full || b_i_ready) nxt++;
      full = 1'b1;
      tick();
    end
    b_i_valid = 1'b0; b_i_ready = 1'b1;
    check_eq("s0_stall", b_o_stall, nstall);
    check_eq("s0_last", b_o_data, exp_out);
    tick();
    check_eq("s0_empty", b_o_valid, 0);
    check_eq("s0_nop", b_o_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
